// File: rtl/pe_stripes_flex.sv
// Bit-serial, variable-precision dot-product PE with valid/ready handshakes and a decoupled result register.
// Optional macro PE_RELU_EN clamps negative results to zero before they are loaded into the output register.
module pe_stripes_flex #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int MP = 16,
    localparam int ACC_W = W + $clog2(N) + MP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_is_msb,
    input  logic               i_is_lsb,
    input  logic               i_a_signed,
    input  logic [N-1:0]       i_vec_a_bits,
    input  logic [N*W-1:0]     i_vec_b,
    input  logic [ACC_W-1:0]   i_initial_sum,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [ACC_W-1:0]   o_dot_product,
    output logic               o_err
);
    localparam int CNT_W = $clog2(MP + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [ACC_W-1:0]   partial;
    logic [ACC_W-1:0]   beat_val;
    logic [ACC_W-1:0]   sum_val;
    logic [ACC_W-1:0]   result;
    logic [CNT_W-1:0]   cnt_inc;
    logic               fire, take, load, overrun, err_d;

    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_vec_a_bits[i])
                partial = partial + ACC_W'($signed(i_vec_b[i*W +: W]));
        end
    end

    // The signed mode only affects the MSB weight, so it is folded into acc
    // on that beat instead of being kept in a separate register.
    always_comb begin
        beat_val = i_is_msb ? (i_a_signed ? -partial : partial)
                            : ((acc_q << 1) + partial);
        cnt_inc  = i_is_msb ? CNT_W'(1) : CNT_W'(cnt_q + 1'b1);
        sum_val  = beat_val + i_initial_sum;
`ifdef PE_RELU_EN
        result   = sum_val[ACC_W-1] ? '0 : sum_val;
`else
        result   = sum_val;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (take)
            state_d = (i_is_lsb || overrun) ? IDLE : BUSY;
    end

    always_comb begin
        o_ready = !o_valid || i_ready;
        fire    = i_valid && o_ready;
        take    = fire && (i_is_msb || state_q == BUSY);
        load    = take && i_is_lsb;
        overrun = take && !i_is_lsb && (cnt_inc == CNT_W'(MP));
        err_d   = (fire && i_is_msb && state_q == BUSY)
               || (fire && !i_is_msb && state_q == IDLE)
               || overrun;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            o_valid       <= 1'b0;
            o_dot_product <= '0;
            o_err         <= 1'b0;
        end else begin
            o_err <= err_d;
            if (take) begin
                acc_q <= beat_val;
                cnt_q <= (i_is_lsb || overrun) ? '0 : cnt_inc;
            end
            if (load) begin
                o_dot_product <= result;
                o_valid       <= 1'b1;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pe_stripes_flex.sv
// Scoreboard bench for pe_stripes_flex: directed operations push expected results, a monitor pops them on output handshakes.
module tb_pe_stripes_flex;
    localparam int N = 4, W = 16, MP = 16, ACC_W = 34;

    logic               clk, rst;
    logic               i_valid, o_ready, i_is_msb, i_is_lsb, i_a_signed;
    logic [N-1:0]       i_vec_a_bits;
    logic [N*W-1:0]     i_vec_b;
    logic [ACC_W-1:0]   i_initial_sum;
    logic               o_valid, i_ready, o_err;
    logic [ACC_W-1:0]   o_dot_product;

    int checks = 0, errors = 0, err_pulses = 0;
    logic [ACC_W-1:0] sb_q[$];

    pe_stripes_flex #(.N(N), .W(W), .MP(MP)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_is_msb(i_is_msb), .i_is_lsb(i_is_lsb), .i_a_signed(i_a_signed),
        .i_vec_a_bits(i_vec_a_bits), .i_vec_b(i_vec_b), .i_initial_sum(i_initial_sum),
        .o_valid(o_valid), .i_ready(i_ready), .o_dot_product(o_dot_product), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] x);
`ifdef PE_RELU_EN
        return x[ACC_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: every output handshake must match the oldest expected value.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_err) err_pulses++;
            if (o_valid && i_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none", $signed(o_dot_product));
                end else begin
                    logic [ACC_W-1:0] e;
                    e = sb_q.pop_front();
                    if (o_dot_product !== e) begin
                        errors++;
                        $display("FAIL result: got %0d expected %0d", $signed(o_dot_product), $signed(e));
                    end
                end
            end
        end
    end

    task automatic beat(input bit msb, input bit lsb, input bit sgn,
                        input logic [3:0] bits, input logic [ACC_W-1:0] init);
        bit rdy;
        int n;
        i_valid = 1'b1; i_is_msb = msb; i_is_lsb = lsb; i_a_signed = sgn;
        i_vec_a_bits = bits; i_initial_sum = init;
        rdy = 1'b0; n = 0;
        while (!rdy && n < 200) begin
            @(negedge clk); rdy = o_ready;
            @(posedge clk); n++;
        end
        #1;
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL beat_timeout: got o_ready=0 expected 1 within 200 cycles");
        end
        i_valid = 1'b0;
    endtask

    task automatic op(input int p, input bit sgn, input int a0, input int a1, input int a2, input int a3,
                      input int init, input int exp, input bit lat);
        logic [31:0] av[4];
        logic [3:0]  bits;
        av[0] = a0; av[1] = a1; av[2] = a2; av[3] = a3;
        sb_q.push_back(relu(ACC_W'(exp)));
        for (int k = 0; k < p; k++) begin
            for (int i = 0; i < 4; i++) bits[i] = av[i][p-1-k];
            beat(k == 0, k == p - 1, sgn, bits, ACC_W'(init));
        end
        if (lat) begin
            @(negedge clk);
            chk("latency_valid", {63'd0, o_valid}, 64'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_is_msb = 1'b0; i_is_lsb = 1'b0; i_a_signed = 1'b0;
        i_vec_a_bits = '0; i_initial_sum = '0; i_ready = 1'b1;
        i_vec_b = {16'sd7, -16'sd1, 16'sd6, 16'sd2};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", {63'd0, o_valid}, 64'd0);
        chk("reset_dot", {30'd0, o_dot_product}, 64'd0);
        chk("reset_err", {63'd0, o_err}, 64'd0);
        chk("reset_ready", {63'd0, o_ready}, 64'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Signed precision 16
        op(16, 1, 1, -4, 6, 3, 0, -7, 1);
        // Back-to-back precision 4: signed then unsigned with bias
        op(4, 1, 1, -4, 6, 3, 0, -7, 0);
        op(4, 0, 1, 12, 6, 3, 100, 189, 1);
        // Precision 1: bits 0011 means lanes 0 and 1 carry -1
        op(1, 1, -1, -1, 0, 0, 5, -3, 1);
        chk("no_err_clean", err_pulses, 0);

        // Backpressure
        @(posedge clk); #1 i_ready = 1'b0;
        op(4, 1, 1, -4, 6, 3, 0, -7, 1);
        fork
            op(4, 0, 1, 12, 6, 3, 100, 189, 1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_ready", {63'd0, o_ready}, 64'd0);
                    chk("stall_hold", {30'd0, o_dot_product}, {30'd0, relu(ACC_W'(-7))});
                end
                @(posedge clk); #1 i_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;
        chk("no_err_backpressure", err_pulses, 0);

        // Non-MSB beat while idle
        beat(0, 0, 1, 4'b1111, '0);
        repeat (2) @(posedge clk); #1;
        chk("err_idle_beat", err_pulses, 1);
        // MSB mid-operation restarts
        beat(1, 0, 1, 4'b1111, '0);
        beat(0, 0, 1, 4'b0101, '0);
        op(4, 1, 1, -4, 6, 3, 0, -7, 1);
        chk("err_msb_restart", err_pulses, 2);
        // MP beats without LSB are discarded
        for (int k = 0; k < MP; k++) beat(k == 0, 0, 1, 4'b0101, '0);
        repeat (2) @(posedge clk); #1;
        chk("err_overrun", err_pulses, 3);
        op(16, 1, 1, -4, 6, 3, 0, -7, 1);

        repeat (4) @(posedge clk); #1;
        chk("err_total", err_pulses, 3);
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("final_valid", {63'd0, o_valid}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_stripes_flex.md
# pe_stripes_flex

Bit-serial dot-product processing element. It takes N signed W-bit B operands in parallel and the A operands one bit per beat, MSB first. Compared with the fixed-precision stripes PE, it adds per-operation precision from 1 to MP bits, a per-operation signed or unsigned A mode, valid/ready handshakes on input and output, a decoupled output register so the next dot product can accumulate while a result waits, and protocol-error reporting. It sits in the PE array between the A bit-stripe sequencer and the partial-sum reduction stage.

## Interface
- N, 4, number of lanes
- W, 16, width of each signed B element
- MP, 16, maximum A precision in bits (≥1)
- ACC_W, W+$clog2(N)+MP, localparam, accumulator and result width
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  beat offered
- o_ready  out  1  beat accepted when i_valid && o_ready
- i_is_msb  in  1  first beat of an operation
- i_is_lsb  in  1  last beat of an operation; may coincide with i_is_msb
- i_a_signed  in  1  sampled on the MSB beat; 1 = A two's complement, 0 = unsigned
- i_vec_a_bits  in  N  current A bit of each lane (lane i = bit i)
- i_vec_b  in  N*W  B operands, lane i at [i*W +: W]; must be stable for the whole operation
- i_initial_sum  in  ACC_W  bias, sampled on the LSB beat
- o_valid  out  1  result held in o_dot_product
- i_ready  in  1  downstream accepts result when o_valid && i_ready
- o_dot_product  out  ACC_W  signed result
- o_err  out  1  one-cycle pulse on a protocol violation

## Operation
- States: IDLE (no operation open) and BUSY (operation open). A beat counter `cnt` (0..MP) counts accepted beats in the current operation.
- `partial` = sum over lanes of sign-extended B[i] where bit i = 1, computed at ACC_W.
- MSB beat (from any state):
  - acc ← (i_a_signed ? −partial : partial)
  - cnt ← 1
  - latch the signed mode
  - next state BUSY, unless the beat is also LSB
- Other accepted beats in BUSY: acc ← 2·acc + partial; cnt ← cnt+1.
- LSB beat:
  - result = (value computed for this beat) + i_initial_sum
  - result is loaded into the output register with o_valid ← 1
  - next state IDLE
- All arithmetic is modulo 2^ACC_W, with no saturation.
- Output register: holds its value while o_valid && !i_ready. It clears o_valid on acceptance unless a new LSB beat loads it in the same cycle.
- o_ready = !o_valid || i_ready. All input beats stall while a result is pending and not being drained. This is combinational from i_ready.
- Boundary conditions:
  - MSB beat while BUSY: abandon the current operation, restart with this beat, pulse o_err.
  - Non-MSB beat in IDLE: no state change, pulse o_err. The beat is still consumed (o_ready as normal).
  - Beat that would make cnt = MP without i_is_lsb: discard the operation, go to IDLE, produce no result, pulse o_err.
  - i_valid low in BUSY: hold acc and cnt; gaps between beats are legal.
  - rst at any time: IDLE, acc=0, cnt=0, o_valid=0, o_dot_product=0, o_err=0. Any in-flight operation is lost.

## Timing
- Reset values of every output: o_valid=0, o_dot_product=0, o_err=0, o_ready=1.
- Latency: o_valid rises in the cycle after the accepted LSB beat.
- Throughput: one operation per P accepted beats, P = precision. Back-to-back operations need no idle beat.
- o_err asserts in the cycle after the offending beat, for exactly one cycle.

## Configuration
- PE_RELU_EN defined: the value loaded into the output register is clamped, so negative results (MSB=1) become 0.
- PE_RELU_EN undefined: the raw signed result is loaded.
- The macro has no effect on timing or handshakes.

## Test plan
- Signed mode, precision 16. Stimulus: A=[1,−4,6,3], B=[2,6,−1,7], initial_sum=0, 16 beats. Required response: o_valid one cycle after the LSB beat, o_dot_product = −7 (ACC_W=34), o_err never asserted.
- Signed mode, precision 4. Stimulus: same A and B, then a second operation back-to-back with unsigned A=[1,12,6,3] and initial_sum=100. Required response: first result −7, second result 189.
- Precision 1, signed. Stimulus: MSB and LSB on the same beat, a-bits=4'b0011, initial_sum=5. Required response: result 5 − (2+6) = −3.
- Backpressure. Stimulus: i_ready held low while result −7 is pending, then a second 4-beat operation is offered. Required response:
  - o_ready low and the second operation stalls
  - o_dot_product stays at −7 until i_ready rises
  - second result follows with no lost or duplicated beats
- Protocol errors. Stimulus:
  - a beat without MSB in IDLE
  - MSB mid-operation
  - MP beats with no LSB

  Required response: one o_err pulse each; no result for the discarded operations; the restarted operation still produces the correct value.
- With PE_RELU_EN defined, the first scenario gives 0 and scenario 2's second result is still 189. With the macro undefined, the first scenario gives −7.
